lsu_data_memory: RTL and testbench
==================================

# lsu_data_memory

Parametrised load/store data memory, the successor to the single-cycle core's word-only data memory. It accepts one request at a time over a valid/ready handshake and executes the RV32I loads and stores LB, LH, LW, LBU, LHU, SB, SH and SW on a little-endian byte-addressed array. Load latency is configurable, and each access returns an explicit error response. It sits between the core's ALU/store-data path and the writeback mux.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- READ_LATENCY, 1: cycles from load accept to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
- rsp_err  out  1  access faulted.

## Operation
- Address decode:
  - word index = req_addr[31:2]; byte lane = req_addr[1:0].
  - Byte lane 0 is bits [7:0] (little-endian).
- States:
  - IDLE: req_ready=1. On req_valid, latch the request. A store goes to RESP; a load goes to WAIT, or directly to RESP when READ_LATENCY=1.
  - WAIT: a down-counter runs from READ_LATENCY-1. When it reaches 1 the state moves to RESP.
  - RESP: rsp_valid=1. Stay until rsp_ready=1, then return to IDLE.
- Store:
  - The array is written on the accept edge, using byte enables derived from funct3 and addr[1:0].
  - SB writes 1 lane, SH writes 2 lanes, SW writes 4 lanes.
  - The response has rdata=0.
- Load:
  - The selected byte or halfword is right-justified.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Error conditions (err=1, rdata=0, no array write):
  - funct3 not in {000, 001, 010, 100, 101};
  - store with funct3 100 or 101;
  - word index ≥ DEPTH_WORDS;
  - misalignment (see Configuration).
- Outputs are held stable while rsp_valid=1 and rsp_ready=0.
- Reset:
  - state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not cleared.
  - A reset mid-operation drops the pending response. A store already accepted remains written.

## Timing
- Accept edge = cycle 0.
- Load: rsp_valid rises at cycle READ_LATENCY.
  - The array is sampled at cycle READ_LATENCY-1, so a store accepted earlier is always visible.
- Store: rsp_valid rises at cycle 1. The array is updated at cycle 0.
- Cycle after the rsp handshake: req_ready=1.
- Maximum throughput is one request per READ_LATENCY+1 cycles when rsp_ready is held high.
- req_ready is 0 outside IDLE. Requests presented there are not accepted, and req_* may change freely.
- No combinational path from req_* to rsp_*. req_ready depends on state only.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses fault with err=1, no write and rdata=0.
  - Halfword is misaligned when addr[0]=1.
  - Word is misaligned when addr[1:0]≠00.
- LSU_MISALIGN_TRAP_EN undefined: the address is aligned down to the access size before lane selection and no alignment fault exists.
  - H/HU ignore addr[0].
  - W ignores addr[1:0].
  - Range and funct3 errors still apply.

## Test plan
- Reset then SW addr 0x40 data 0xDEADBEEF, then LW 0x40:
  - rsp_rdata=0xDEADBEEF, err=0;
  - store rsp at cycle 1; load rsp at cycle READ_LATENCY.
- Sub-word loads after the above:
  - LB 0x43 -> 0xFFFFFFDE;
  - LBU 0x43 -> 0x000000DE;
  - LH 0x42 -> 0xFFFFDEAD;
  - LHU 0x40 -> 0x0000BEEF.
- Byte enables: SB 0x41 data 0x12345677, then LW 0x40 -> 0xDEAD77EF. SH 0x42 data 0x0000AAAA, then LW 0x40 -> 0xAAAA77EF.
- Faults:
  - LW at word index DEPTH_WORDS -> err=1, rdata=0;
  - SB with funct3=100 -> err=1 and memory unchanged;
  - with LSU_MISALIGN_TRAP_EN, LW 0x41 -> err=1;
  - without it, LW 0x41 -> 0xAAAA77EF.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. rsp_valid, rdata and err stay stable, req_ready=0, and a new req_valid is not accepted. Release rsp_ready: req_ready=1 on the next cycle.
- Reset during WAIT (READ_LATENCY=4, assert rst at cycle 2): rsp_valid is never asserted, req_ready=1 after reset, and prior stores are still readable.

Source files
------------

// File: rtl/lsu_data_memory_if.sv
// Load/store request/response bundle for lsu_data_memory.
// The master (core side) drives requests and rsp_ready. The slave (memory side) drives
// req_ready and the response fields.
interface lsu_data_memory_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_data_memory.sv
// RV32I load/store data memory (LB/LH/LW/LBU/LHU/SB/SH/SW), little-endian, one request in
// flight at a time over a valid/ready handshake with configurable load latency.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned halfword/word
// accesses fault. When undefined, addresses are aligned down to the access size.
module lsu_data_memory #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  lsu_data_memory_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [IdxW-1:0]   idx_q;
  logic              err_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              mem_we;
  logic [1:0]        req_lane;
  logic [IdxW-1:0]   req_idx;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata_rep;
  logic              f3_err;
  logic              range_err;
  logic              misalign_err;
  logic              req_err;

  // Picks the addressed byte/halfword out of a word and extends it per funct3.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3Byte:  res = {{24{b[7]}}, b};
      F3Half:  res = {{16{h[15]}}, h};
      F3Word:  res = word;
      F3ByteU: res = {24'd0, b};
      F3HalfU: res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept = (state_q == StIdle) && bus.req_valid;
  // Reset wins over a same-cycle accept, so a store is written only if it was really taken.
  assign mem_we = accept && bus.req_we && !req_err && !rst;

  // Decode the incoming request: aligned lane, byte enables, replicated store data, faults.
  always_comb begin
    req_lane      = bus.req_addr[1:0];
    req_idx       = bus.req_addr[IdxW+1:2];
    req_be        = 4'b0000;
    req_wdata_rep = bus.req_wdata;
    f3_err        = 1'b0;
    case (bus.req_funct3)
      F3Byte, F3ByteU: begin
        req_be        = 4'b0001 << req_lane;
        req_wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      F3Half, F3HalfU: begin
        req_lane      = {bus.req_addr[1], 1'b0};
        req_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      F3Word: begin
        req_lane = 2'd0;
        req_be   = 4'b1111;
      end
      default: f3_err = 1'b1;
    endcase
    // Unsigned variants only make sense for loads.
    if (bus.req_we && (bus.req_funct3 == F3ByteU || bus.req_funct3 == F3HalfU)) begin
      f3_err = 1'b1;
    end
    range_err = ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_err = ((bus.req_funct3 == F3Half || bus.req_funct3 == F3HalfU) && bus.req_addr[0])
                || ((bus.req_funct3 == F3Word) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign_err = 1'b0;
`endif
    req_err = f3_err | range_err | misalign_err;
  end

  // Byte-enabled store on the accept edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) begin
          mem[req_idx][8*b +: 8] <= req_wdata_rep[8*b +: 8];
        end
      end
    end
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            funct3_q <= bus.req_funct3;
            lane_q   <= req_lane;
            idx_q    <= req_idx;
            err_q    <= req_err;
            if (bus.req_we || (READ_LATENCY == 1)) begin
              // Stores and single-cycle loads respond straight away; for a load the array
              // is sampled here, which is cycle READ_LATENCY-1.
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= req_err;
              rsp_rdata_q <= (bus.req_we || req_err) ? 32'd0
                           : load_extract(mem[req_idx], bus.req_funct3, req_lane);
            end else begin
              state_q <= StWait;
              cnt_q   <= 3'(READ_LATENCY - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == 3'd1) begin
            // Sample the array on the last wait edge so earlier stores are always visible.
            state_q     <= StResp;
            cnt_q       <= 3'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= err_q ? 32'd0 : load_extract(mem[idx_q], funct3_q, lane_q);
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench for lsu_data_memory with a 4-cycle load latency.
module tb_lsu_data_memory;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned RL    = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lsu_data_memory_if bus ();

  lsu_data_memory #(
    .DEPTH_WORDS  (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, measure latency, check response, handshake.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int guard;
    int lat;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.req_ready) begin
      check({tag, " ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), we ? 32'd1 : 32'(RL));
    check({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, " err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, " ready_after"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_rdata;
    logic        held_err;
    logic        seen;
    int          guard;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store then load back, sub-word loads.
    do_req("sw40", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("lb43", 1'b0, 3'b000, 32'h43, 32'h0, 32'hFFFFFFDE, 1'b0);
    do_req("lbu43", 1'b0, 3'b100, 32'h43, 32'h0, 32'h000000DE, 1'b0);
    do_req("lh42", 1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFFDEAD, 1'b0);
    do_req("lhu40", 1'b0, 3'b101, 32'h40, 32'h0, 32'h0000BEEF, 1'b0);

    // Byte enables.
    do_req("sb41", 1'b1, 3'b000, 32'h41, 32'h12345677, 32'h0, 1'b0);
    do_req("lw40_sb", 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEAD77EF, 1'b0);
    do_req("sh42", 1'b1, 3'b001, 32'h42, 32'h0000AAAA, 32'h0, 1'b0);
    do_req("lw40_sh", 1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAA77EF, 1'b0);

    // Faults: out of range, illegal store funct3, undefined funct3.
    do_req("lw_range", 1'b0, 3'b010, DEPTH * 4, 32'h0, 32'h0, 1'b1);
    do_req("sw_range", 1'b1, 3'b010, DEPTH * 4 + 32'h40, 32'h5A5A5A5A, 32'h0, 1'b1);
    do_req("sbu_store", 1'b1, 3'b100, 32'h40, 32'h00000055, 32'h0, 1'b1);
    do_req("lw40_unch", 1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAA77EF, 1'b0);
    do_req("f3_011", 1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1);

    // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw41", 1'b0, 3'b010, 32'h41, 32'h0, 32'h0, 1'b1);
    do_req("lh43", 1'b0, 3'b001, 32'h43, 32'h0, 32'h0, 1'b1);
    do_req("sh41", 1'b1, 3'b001, 32'h41, 32'h00001234, 32'h0, 1'b1);
`else
    do_req("lw41", 1'b0, 3'b010, 32'h41, 32'h0, 32'hAAAA77EF, 1'b0);
    do_req("lh43", 1'b0, 3'b001, 32'h43, 32'h0, 32'hFFFFAAAA, 1'b0);
    do_req("sh41", 1'b1, 3'b001, 32'h41, 32'h00001234, 32'h0, 1'b0);
    do_req("lw40_sh41", 1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAA1234, 1'b0);
    do_req("sh41_undo", 1'b1, 3'b001, 32'h40, 32'h000077EF, 32'h0, 1'b0);
`endif

    // Backpressure: response held, competing store must not be taken.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.rsp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("bp rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    held_rdata     = bus.rsp_rdata;
    held_err       = bus.rsp_err;
    check("bp rdata first", held_rdata, 32'hAAAA77EF);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp hold rdata", bus.rsp_rdata, 32'hAAAA77EF);
      check("bp hold err", {31'd0, bus.rsp_err}, {31'd0, held_err});
      check("bp req_ready low", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("bp release ready", {31'd0, bus.req_ready}, 32'd1);
    check("bp release valid", {31'd0, bus.rsp_valid}, 32'd0);
    do_req("bp not_taken", 1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAA77EF, 1'b0);

    // Reset at cycle 2 of a 4-cycle load drops the response.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    seen = bus.rsp_valid;
    @(posedge clk); #1;
    seen = seen | bus.rsp_valid;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wait req_ready", {31'd0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      seen = seen | bus.rsp_valid;
      @(posedge clk); #1;
    end
    check("rst_wait no rsp", {31'd0, seen}, 32'd0);
    do_req("rst_wait lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAA77EF, 1'b0);
    do_req("rst_wait lbu41", 1'b0, 3'b100, 32'h41, 32'h0, 32'h00000077, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
